// File: rtl/pll_rst_ctrl.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for lock with timeout/retry,
// qualifies lock stability, then releases sys_rst_n. Optional: PLL_RST_CTRL_LOSS_CNT_EN.
module pll_rst_ctrl #(
  parameter int RST_HOLD_CYC    = 16,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int MAX_RETRY       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       user_rst_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fail,
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  output logic [7:0] lock_loss_cnt,
`endif
  output logic [3:0] retry_cnt
);

  localparam int MAX_AB  = (RST_HOLD_CYC > LOCK_TIMEOUT) ? RST_HOLD_CYC : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_LIM    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RESET_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [1:0]       sync_q;
  logic             lock_s;
  logic             pll_rst_q, sys_rst_n_q, locked_q, fail_q;

  // Lock from a PLL held in reset is meaningless, so the synchroniser is flushed
  // while pll_rst is asserted; lock is only believed once the PLL runs freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else if (pll_rst_q) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_lock};
    end
  end

  assign lock_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET_HOLD;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == ST_RESET_HOLD) || (state_d == ST_FAIL);
      sys_rst_n_q <= (state_d == ST_RUN);
      locked_q    <= (state_d == ST_RUN);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (user_rst_req) begin
      state_d = ST_RESET_HOLD;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        ST_RESET_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == RETRY_LIM) ? ST_FAIL : ST_RESET_HOLD;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = 4'd0;
          end
        end
        ST_RUN: begin
          if (!lock_s) state_d = ST_RESET_HOLD;
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_RESET_HOLD;
      endcase
    end
  end

  // Counter only runs in the timed states, so RUN/FAIL can never wrap it.
  always_comb begin
    cnt_d = cnt_q;
    if (user_rst_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RESET_HOLD) || (state_q == ST_WAIT_LOCK) ||
                 (state_q == ST_STABLE)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic       loss_event;

  assign loss_event = (state_q == ST_RUN) && !lock_s && !user_rst_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= 8'd0;
    end else if (loss_event && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`endif

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed bench for pll_rst_ctrl: a vector table for the main sequences plus hand
// sequences for lock loss in RUN, a lock glitch in STABLE and async reset.
module tb_pll_rst_ctrl;

  localparam int RST_HOLD_CYC    = 4;
  localparam int LOCK_TIMEOUT    = 32;
  localparam int LOCK_STABLE_CYC = 8;
  localparam int MAX_RETRY       = 2;
  localparam int NVEC            = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       user_rst_req = 1'b0;
  logic       pll_rst, sys_rst_n, locked, fail;
  logic [3:0] retry_cnt;
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pll_rst_ctrl #(
    .RST_HOLD_CYC    (RST_HOLD_CYC),
    .LOCK_TIMEOUT    (LOCK_TIMEOUT),
    .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
    .MAX_RETRY       (MAX_RETRY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .user_rst_req (user_rst_req),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .locked       (locked),
    .fail         (fail),
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {pll_rst, sys_rst_n, locked, fail, retry_cnt}.
  typedef struct {
    bit         do_rst;
    bit         lock;
    bit         req;
    int         adv;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic logic [7:0] ob(input bit pr, input bit sn, input bit lk,
                                    input bit f, input logic [3:0] rc);
    return {pr, sn, lk, f, rc};
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = {pll_rst, sys_rst_n, locked, fail, retry_cnt};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pll_rst=%b sys_rst_n=%b locked=%b fail=%b retry_cnt=%0d, expected pll_rst=%b sys_rst_n=%b locked=%b fail=%b retry_cnt=%0d",
               name, got[7], got[6], got[5], got[4], got[3:0],
               exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end else begin
      $display("ok   %s: outputs=%b", name, got);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    user_rst_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance n rising edges (user_rst_req lasts only for the first), end on a falling edge.
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 user_rst_req = 1'b0;
    end
    if (n > 0) @(negedge clk);
  endtask

  initial begin
    // Power-up with lock present: RUN at edge 15, then a user request from RUN.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 0,  ob(1, 0, 0, 0, 4'd0)};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 3,  ob(1, 0, 0, 0, 4'd0)};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1,  ob(0, 0, 0, 0, 4'd0)};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 10, ob(0, 0, 0, 0, 4'd0)};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1,  ob(0, 1, 1, 0, 4'd0)};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1,  ob(1, 0, 0, 0, 4'd0)};
    // No lock: timeouts at edges 36 and 72, FAIL is terminal.
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 35, ob(0, 0, 0, 0, 4'd0)};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1,  ob(1, 0, 0, 0, 4'd1)};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 3,  ob(1, 0, 0, 0, 4'd1)};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1,  ob(0, 0, 0, 0, 4'd1)};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 31, ob(0, 0, 0, 0, 4'd1)};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1,  ob(1, 0, 0, 1, 4'd2)};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 20, ob(1, 0, 0, 1, 4'd2)};
    // User request out of FAIL, then relock.
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1,  ob(1, 0, 0, 0, 4'd0)};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 3,  ob(1, 0, 0, 0, 4'd0)};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1,  ob(0, 0, 0, 0, 4'd0)};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 10, ob(0, 0, 0, 0, 4'd0)};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1,  ob(0, 1, 1, 0, 4'd0)};
    // User request on the timeout edge wins: no retry counted.
    vecs[18] = '{1'b1, 1'b0, 1'b0, 35, ob(0, 0, 0, 0, 4'd0)};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1,  ob(1, 0, 0, 0, 4'd0)};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 4,  ob(0, 0, 0, 0, 4'd0)};
    // One timeout, then lock: retry_cnt clears on RUN entry.
    vecs[21] = '{1'b1, 1'b0, 1'b0, 36, ob(1, 0, 0, 0, 4'd1)};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 14, ob(0, 0, 0, 0, 4'd1)};
    vecs[23] = '{1'b0, 1'b1, 1'b0, 1,  ob(0, 1, 1, 0, 4'd0)};

    for (int v = 0; v < NVEC; v++) begin
      if (vecs[v].do_rst) begin
        pll_lock = vecs[v].lock;
        do_reset();
      end
      pll_lock = vecs[v].lock;
      user_rst_req = vecs[v].req;
      advance(vecs[v].adv);
      check($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Lock loss in RUN, three times: drop seen after 3 edges, relock after 15 more.
    pll_lock = 1'b1;
    do_reset();
    advance(17);
    check("run_entry", ob(0, 1, 1, 0, 4'd0));
    for (int k = 0; k < 3; k++) begin
      pll_lock = 1'b0;
      advance(2);
      check($sformatf("loss%0d_sync", k), ob(0, 1, 1, 0, 4'd0));
      advance(1);
      check($sformatf("loss%0d_drop", k), ob(1, 0, 0, 0, 4'd0));
      pll_lock = 1'b1;
      advance(14);
      check($sformatf("loss%0d_relock_pre", k), ob(0, 0, 0, 0, 4'd0));
      advance(1);
      check($sformatf("loss%0d_relock", k), ob(0, 1, 1, 0, 4'd0));
    end
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd3) begin
      errors++;
      $display("FAIL lock_loss_cnt: got %0d, expected 3", lock_loss_cnt);
    end else begin
      $display("ok   lock_loss_cnt: %0d", lock_loss_cnt);
    end
`endif

    // One-cycle lock glitch at STABLE cnt=5: back to WAIT_LOCK, RUN delayed to edge 24.
    pll_lock = 1'b1;
    do_reset();
    advance(12);
    check("glitch_stable5", ob(0, 0, 0, 0, 4'd0));
    pll_lock = 1'b0;
    advance(1);
    pll_lock = 1'b1;
    for (int e = 14; e <= 23; e++) begin
      advance(1);
      check($sformatf("glitch_edge%0d", e), ob(0, 0, 0, 0, 4'd0));
    end
    advance(1);
    check("glitch_run", ob(0, 1, 1, 0, 4'd0));

    // Asynchronous reset mid-STABLE and in RUN.
    pll_lock = 1'b1;
    do_reset();
    advance(10);
    check("async_pre", ob(0, 0, 0, 0, 4'd0));
    #2 rst_n = 1'b0;
    #1 check("async_stable", ob(1, 0, 0, 0, 4'd0));
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL lock_loss_cnt_rst: got %0d, expected 0", lock_loss_cnt);
    end else begin
      $display("ok   lock_loss_cnt_rst: %0d", lock_loss_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    advance(14);
    check("async_seq_pre", ob(0, 0, 0, 0, 4'd0));
    advance(1);
    check("async_seq_run", ob(0, 1, 1, 0, 4'd0));
    advance(3);
    #2 rst_n = 1'b0;
    #1 check("async_run", ob(1, 0, 0, 0, 4'd0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
